glb_bank_sched: RTL and testbench

Per-bank access scheduler for the global buffer. Shares one single-ported GLB bank between NUM_REQ requesters (processor packet path, streaming write path, streaming read path) and registers one granted access per cycle onto the bank's write/read-request ports. It also routes each returning read response to the requester that issued it, using a tag pipeline matched to the bank read latency. An SRAM-config stall input lets configuration traffic take the bank exclusively.

---
 rtl/glb_bank_sched.sv | 151 +++++++++++++++
 tb/tb_glb_bank_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_bank_sched.sv
// Per-bank access scheduler for a single-ported GLB bank: round-robin grant,
// registered issue onto the bank ports, and tag-based read response routing.
module glb_bank_sched #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_stall,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
  output logic                            bank_wr_en,
  output logic [ADDR_WIDTH-1:0]           bank_wr_addr,
  output logic [DATA_WIDTH-1:0]           bank_wr_data,
  output logic [DATA_WIDTH/8-1:0]         bank_wr_strb,
  output logic                            bank_rd_en,
  output logic [ADDR_WIDTH-1:0]           bank_rd_addr,
  input  logic [DATA_WIDTH-1:0]           bank_rd_data,
  input  logic                            bank_rd_data_valid,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            err_orphan_rsp
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]       r_rr_ptr;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_gnt_id;
  logic                  w_found;
  int unsigned           w_best_dist;
  int unsigned           w_dist;
  logic                  w_xfer;
  logic                  w_gnt_wr;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [STRB_W-1:0]     w_gnt_strb;

  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [STRB_W-1:0]     r_wr_strb;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [RD_LATENCY:0]   r_tag_vld;
  logic [ID_W-1:0]       r_tag_id [RD_LATENCY+1];
  logic                  r_err;

  // Priority is the rotational distance from r_rr_ptr; the closest valid requester wins.
  always_comb begin
    w_found     = 1'b0;
    w_gnt_id    = '0;
    w_best_dist = NUM_REQ;
    w_dist      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 32'(r_rr_ptr)) % NUM_REQ;
      if (req_valid[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_gnt_id    = ID_W'(i);
        w_found     = 1'b1;
      end
    end
    if (cfg_stall || !reset) begin
      w_found = 1'b0;
    end
    w_grant    = '0;
    w_gnt_wr   = 1'b0;
    w_gnt_addr = '0;
    w_gnt_data = '0;
    w_gnt_strb = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_found && (w_gnt_id == ID_W'(i))) begin
        w_grant[i] = 1'b1;
        w_gnt_wr   = req_wr[i];
        w_gnt_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_gnt_strb = req_strb[i*STRB_W +: STRB_W];
      end
    end
  end

  assign req_ready = w_grant;
  assign w_xfer    = w_found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_tag_vld <= '0;
      for (int unsigned s = 0; s <= RD_LATENCY; s++) begin
        r_tag_id[s] <= '0;
      end
      r_err     <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_rr_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
      r_wr_en <= w_xfer & w_gnt_wr;
      r_rd_en <= w_xfer & ~w_gnt_wr;
      if (w_xfer && w_gnt_wr) begin
        r_wr_addr <= w_gnt_addr;
        r_wr_data <= w_gnt_data;
        r_wr_strb <= w_gnt_strb;
      end
      if (w_xfer && !w_gnt_wr) begin
        r_rd_addr <= w_gnt_addr;
      end
      // Stage 0 sits alongside bank_rd_en; stage RD_LATENCY lines up with the returning data.
      r_tag_vld[0] <= w_xfer & ~w_gnt_wr;
      r_tag_id[0]  <= w_gnt_id;
      for (int unsigned s = 1; s <= RD_LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
      if (bank_rd_data_valid && !r_tag_vld[RD_LATENCY]) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bank_rd_data_valid && r_tag_vld[RD_LATENCY] && (r_tag_id[RD_LATENCY] == ID_W'(i))) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  assign rsp_data       = bank_rd_data;
  assign bank_wr_en     = r_wr_en;
  assign bank_wr_addr   = r_wr_addr;
  assign bank_wr_data   = r_wr_data;
  assign bank_wr_strb   = r_wr_strb;
  assign bank_rd_en     = r_rd_en;
  assign bank_rd_addr   = r_rd_addr;
  assign err_orphan_rsp = r_err;

endmodule

// File: tb/tb_glb_bank_sched.sv
// Directed bench for glb_bank_sched: grant order, issue latency, response routing,
// config stall, orphan/dropped responses and asynchronous reset.
module tb_glb_bank_sched;

  localparam int N  = 3;
  localparam int AW = 17;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic            clk;
  logic            reset;
  logic            cfg_stall;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*SW-1:0] req_strb;
  logic            bank_wr_en;
  logic [AW-1:0]   bank_wr_addr;
  logic [DW-1:0]   bank_wr_data;
  logic [SW-1:0]   bank_wr_strb;
  logic            bank_rd_en;
  logic [AW-1:0]   bank_rd_addr;
  logic [DW-1:0]   bank_rd_data;
  logic            bank_rd_data_valid;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            err_orphan_rsp;

  int n_vec;
  int n_err;

  glb_bank_sched #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RD_LATENCY(2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_stall         (cfg_stall),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_wr            (req_wr),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .req_strb          (req_strb),
    .bank_wr_en        (bank_wr_en),
    .bank_wr_addr      (bank_wr_addr),
    .bank_wr_data      (bank_wr_data),
    .bank_wr_strb      (bank_wr_strb),
    .bank_rd_en        (bank_rd_en),
    .bank_rd_addr      (bank_rd_addr),
    .bank_rd_data      (bank_rd_data),
    .bank_rd_data_valid(bank_rd_data_valid),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .err_orphan_rsp    (err_orphan_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gidx [6];
    gidx = '{2, 0, 1, 2, 0, 1};
    n_vec = 0;
    n_err = 0;

    reset = 1'b0;
    cfg_stall = 1'b0;
    req_valid = 3'b111;
    req_wr = '0;
    req_addr = '0;
    req_data = '0;
    req_strb = '0;
    bank_rd_data = '0;
    bank_rd_data_valid = 1'b0;

    #3;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_wr_en", 64'(bank_wr_en), 64'h0);
    chk("rst_rd_en", 64'(bank_rd_en), 64'h0);
    chk("rst_wr_addr", 64'(bank_wr_addr), 64'h0);
    chk("rst_wr_data", bank_wr_data, 64'h0);
    chk("rst_wr_strb", 64'(bank_wr_strb), 64'h0);
    chk("rst_rd_addr", 64'(bank_rd_addr), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_err", 64'(err_orphan_rsp), 64'h0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;

    // Single write by requester 1
    cyc();
    req_valid = 3'b010;
    req_wr = 3'b010;
    req_addr[1*AW +: AW] = 17'h00010;
    req_data[1*DW +: DW] = 64'hDEADBEEF_00000001;
    req_strb[1*SW +: SW] = 8'hFF;
    #1;
    chk("wr_ready", 64'(req_ready), 64'h2);
    cyc();
    req_valid = '0;
    #1;
    chk("wr_en", 64'(bank_wr_en), 64'h1);
    chk("wr_addr", 64'(bank_wr_addr), 64'h10);
    chk("wr_data", bank_wr_data, 64'hDEADBEEF_00000001);
    chk("wr_strb", 64'(bank_wr_strb), 64'hFF);
    chk("wr_no_rd", 64'(bank_rd_en), 64'h0);

    // All three requesters reading continuously; pointer starts at 2
    req_wr = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(17'h100 + i);
    for (int k = 0; k < 9; k++) begin
      cyc();
      req_valid = (k < 6) ? 3'b111 : 3'b000;
      bank_rd_data_valid = (k >= 3);
      bank_rd_data = 64'hA0 + 64'(k);
      #1;
      if (k == 0) begin
        chk("wr_en_drop", 64'(bank_wr_en), 64'h0);
        chk("wr_addr_hold", 64'(bank_wr_addr), 64'h10);
      end
      if (k < 6) chk("rr_ready", 64'(req_ready), 64'(3'b001 << gidx[k]));
      chk("rr_rd_en", 64'(bank_rd_en), (k >= 1 && k <= 6) ? 64'h1 : 64'h0);
      if (k >= 1 && k <= 6) chk("rr_rd_addr", 64'(bank_rd_addr), 64'(17'h100 + gidx[k-1]));
      chk("rr_rsp_valid", 64'(rsp_valid), (k >= 3) ? 64'(3'b001 << gidx[k-3]) : 64'h0);
      if (k >= 3) chk("rr_rsp_data", rsp_data, 64'hA0 + 64'(k));
    end
    cyc();
    bank_rd_data_valid = 1'b0;
    #1;
    chk("rr_err", 64'(err_orphan_rsp), 64'h0);
    chk("rr_idle_rd_en", 64'(bank_rd_en), 64'h0);

    // Requester 0 read round trip
    cyc();
    req_valid = 3'b001;
    req_addr[0 +: AW] = 17'h1F000;
    #1;
    chk("r0_ready", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    #1;
    chk("r0_rd_en", 64'(bank_rd_en), 64'h1);
    chk("r0_rd_addr", 64'(bank_rd_addr), 64'h1F000);
    cyc();
    #1;
    chk("r0_early", 64'(rsp_valid), 64'h0);
    cyc();
    bank_rd_data_valid = 1'b1;
    bank_rd_data = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("r0_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("r0_rsp_data", rsp_data, 64'h0123_4567_89AB_CDEF);
    cyc();
    bank_rd_data_valid = 1'b0;
    #1;
    chk("r0_err", 64'(err_orphan_rsp), 64'h0);

    // Config stall with a read already issued; pointer is 1 here
    cyc();
    req_valid = 3'b100;
    req_addr[2*AW +: AW] = 17'h00200;
    #1;
    chk("st_pre_ready", 64'(req_ready), 64'h4);
    cyc();
    cfg_stall = 1'b1;
    req_valid = 3'b101;
    #1;
    chk("st_ready1", 64'(req_ready), 64'h0);
    chk("st_rd_en1", 64'(bank_rd_en), 64'h1);
    chk("st_rd_addr1", 64'(bank_rd_addr), 64'h200);
    cyc();
    #1;
    chk("st_ready2", 64'(req_ready), 64'h0);
    chk("st_rd_en2", 64'(bank_rd_en), 64'h0);
    chk("st_wr_en2", 64'(bank_wr_en), 64'h0);
    cyc();
    bank_rd_data_valid = 1'b1;
    bank_rd_data = 64'h55;
    #1;
    chk("st_ready3", 64'(req_ready), 64'h0);
    chk("st_rsp_valid", 64'(rsp_valid), 64'h4);
    cyc();
    bank_rd_data_valid = 1'b0;
    #1;
    chk("st_ready4", 64'(req_ready), 64'h0);
    chk("st_rd_en4", 64'(bank_rd_en), 64'h0);
    cyc();
    cfg_stall = 1'b0;
    #1;
    chk("st_release_ready", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    #1;
    chk("st_release_rd_en", 64'(bank_rd_en), 64'h1);
    chk("st_release_addr", 64'(bank_rd_addr), 64'h1F000);
    cyc();
    cyc();
    #1;
    chk("drop_rsp_valid", 64'(rsp_valid), 64'h0);
    cyc();
    #1;
    chk("drop_err", 64'(err_orphan_rsp), 64'h0);

    // Orphan response
    cyc();
    bank_rd_data_valid = 1'b1;
    #1;
    chk("orph_rsp_valid", 64'(rsp_valid), 64'h0);
    cyc();
    bank_rd_data_valid = 1'b0;
    #1;
    chk("orph_err", 64'(err_orphan_rsp), 64'h1);
    cyc();
    cyc();
    #1;
    chk("orph_sticky", 64'(err_orphan_rsp), 64'h1);

    // Reset with two reads in flight; pointer is 1 here
    cyc();
    req_valid = 3'b010;
    req_addr[1*AW +: AW] = 17'h00111;
    #1;
    chk("mr_ready0", 64'(req_ready), 64'h2);
    cyc();
    req_valid = 3'b100;
    #1;
    chk("mr_ready1", 64'(req_ready), 64'h4);
    chk("mr_rd_addr0", 64'(bank_rd_addr), 64'h111);
    cyc();
    req_valid = '0;
    #1;
    chk("mr_rd_en_pre", 64'(bank_rd_en), 64'h1);
    chk("mr_rd_addr1", 64'(bank_rd_addr), 64'h200);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_rd_en", 64'(bank_rd_en), 64'h0);
    chk("mr_rd_addr", 64'(bank_rd_addr), 64'h0);
    chk("mr_wr_addr", 64'(bank_wr_addr), 64'h0);
    chk("mr_wr_data", bank_wr_data, 64'h0);
    chk("mr_err", 64'(err_orphan_rsp), 64'h0);
    req_valid = 3'b111;
    #1;
    chk("mr_ready_in_rst", 64'(req_ready), 64'h0);
    cyc();
    req_valid = '0;
    #3;
    reset = 1'b1;
    bank_rd_data_valid = 1'b1;
    #1;
    chk("mr_old_tag", 64'(rsp_valid), 64'h0);
    cyc();
    bank_rd_data_valid = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("mr_orphan_after", 64'(err_orphan_rsp), 64'h1);
    chk("mr_first_grant", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    #1;
    chk("mr_first_rd_en", 64'(bank_rd_en), 64'h1);
    chk("mr_first_addr", 64'(bank_rd_addr), 64'h1F000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
